// File: rtl/grid_pkg.sv
// Shared types and constants for grid-based sprite controllers.
package grid_pkg;

    localparam int unsigned COORD_W       = 10;
    localparam int unsigned TILE_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_R = 2'd1,
        DIR_D = 2'd2,
        DIR_L = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        FRAME_STAND = 2'd0,
        FRAME_WALKA = 2'd1,
        FRAME_WALKB = 2'd2,
        FRAME_DEATH = 2'd3
    } frame_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    // Walk cycle: stand, walkA, stand, walkB.
    function automatic frame_e phase_frame(input logic [1:0] phase);
        case (phase)
            2'd1:    return FRAME_WALKA;
            2'd3:    return FRAME_WALKB;
            default: return FRAME_STAND;
        endcase
    endfunction

endpackage

// File: rtl/grid_sprite_ctrl_if.sv
// Control/status bundle between game logic (master) and a sprite controller (slave).
interface grid_sprite_ctrl_if
    import grid_pkg::*;
#(
    parameter int unsigned SPD_W = 2
);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               go;
    dir_e               dir;
    logic [SPD_W-1:0]   speed;
    logic               freeze;
    logic               dead;
    logic               load;
    logic [COORD_W-1:0] ld_x;
    logic [COORD_W-1:0] ld_y;

    logic [COORD_W-1:0] x_s;
    logic [COORD_W-1:0] y_s;
    logic               sprite_on;
    logic               hb_on;
    frame_e             frame;
    logic               mirror;
    logic               step;
    logic               aligned;

    modport master (
        output x, y, go, dir, speed, freeze, dead, load, ld_x, ld_y,
        input  x_s, y_s, sprite_on, hb_on, frame, mirror, step, aligned
    );

    modport slave (
        input  x, y, go, dir, speed, freeze, dead, load, ld_x, ld_y,
        output x_s, y_s, sprite_on, hb_on, frame, mirror, step, aligned
    );

endinterface

// File: rtl/rate_divider.sv
// Enable-gated tick generator; ">=" compare lets a shortened period fire at once instead of wrapping.
module rate_divider #(
    parameter int unsigned W = 21
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = en && (cnt >= (period - W'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/grid_sprite_ctrl.sv
// Sprite motion on a pillar grid: 1 px steps, pillar collision with corner slide,
// arena clamp, respawn load and animation frame selection.
module grid_sprite_ctrl
    import grid_pkg::*;
#(
    parameter int unsigned TILE_LOG2    = TILE_LOG2_DEF,
    parameter int unsigned SPR_W        = 16,
    parameter int unsigned SPR_H        = 25,
    parameter int unsigned HB_OFF       = 9,
    parameter int unsigned AX0          = 48,
    parameter int unsigned AY0          = 32,
    parameter int unsigned AX1          = 576,
    parameter int unsigned AY1          = 448,
    parameter int unsigned START_X      = 64,
    parameter int unsigned START_Y      = 23,
    parameter int unsigned BASE_PERIOD  = 1200000,
    parameter int unsigned PERIOD_STEP  = 200000,
    parameter int unsigned SPD_W        = 2,
    parameter int unsigned FRAME_PERIOD = 12500000
) (
    input logic              clk,
    input logic              reset,
    grid_sprite_ctrl_if.slave bus
);

    localparam int unsigned PW   = $clog2(BASE_PERIOD + 1);
    localparam int unsigned FW   = $clog2(FRAME_PERIOD + 1);
    localparam int unsigned CW1  = COORD_W + 1;
    localparam int unsigned HB_H = SPR_H - HB_OFF;

    localparam logic [COORD_W-1:0] X_MIN = COORD_W'(AX0);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(AX1 - SPR_W);
    localparam logic [COORD_W-1:0] Y_MIN = COORD_W'(AY0 - HB_OFF);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(AY1 - SPR_H);

    localparam logic [COORD_W-1:0] SX_REL    = COORD_W'(START_X - AX0);
    localparam logic [COORD_W-1:0] SY_REL    = COORD_W'(START_Y + HB_OFF - AY0);
    localparam logic               ALIGN_RST = (SX_REL[TILE_LOG2-1:0] == '0) &&
                                               (SY_REL[TILE_LOG2-1:0] == '0);

    pos_t       pos_q, pos_mv, pos_nxt;
    logic [1:0] phase_q, phase_nxt;
    frame_e     frame_q;
    logic       step_q, mirror_q, aligned_q;

    logic [SPD_W-1:0] spd;
    logic [PW-1:0]    period;
    logic             en, mv_tick, fr_tick;

    assign spd    = bus.speed;
    assign period = PW'(BASE_PERIOD) - PW'(PW'(spd) * PW'(PERIOD_STEP));
    assign en     = bus.go && !bus.freeze && !bus.load;

    rate_divider #(.W(PW)) u_move_div (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .period (period),
        .tick   (mv_tick)
    );

    rate_divider #(.W(FW)) u_anim_div (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .period (FW'(FRAME_PERIOD)),
        .tick   (fr_tick)
    );

    // Arena-relative hitbox edges and their neighbours, modulo 2**COORD_W.
    logic [COORD_W-1:0] hl, hr, ht, hb, hl_m1, hr_p1, ht_m1, hb_p1;
    logic col_l, col_r, row_t, row_b, col_hit, row_hit;
    logic slide_l, slide_r, slide_u, slide_d;

    assign hl    = pos_q.x - X_MIN;
    assign hr    = hl + COORD_W'(SPR_W - 1);
    assign ht    = pos_q.y + COORD_W'(HB_OFF) - COORD_W'(AY0);
    assign hb    = ht + COORD_W'(HB_H - 1);
    assign hl_m1 = hl - COORD_W'(1);
    assign hr_p1 = hr + COORD_W'(1);
    assign ht_m1 = ht - COORD_W'(1);
    assign hb_p1 = hb + COORD_W'(1);

    assign col_l   = hl[TILE_LOG2];
    assign col_r   = hr[TILE_LOG2];
    assign row_t   = ht[TILE_LOG2];
    assign row_b   = hb[TILE_LOG2];
    assign col_hit = col_l || col_r;
    assign row_hit = row_t || row_b;

    // Slide only when one edge overlaps the pillar and the open side is free.
    assign slide_l = col_r && !col_l && !hl_m1[TILE_LOG2] && (pos_q.x > X_MIN);
    assign slide_r = col_l && !col_r && !hr_p1[TILE_LOG2] && (pos_q.x < X_MAX);
    assign slide_u = row_b && !row_t && !ht_m1[TILE_LOG2] && (pos_q.y > Y_MIN);
    assign slide_d = row_t && !row_b && !hb_p1[TILE_LOG2] && (pos_q.y < Y_MAX);

    always_comb begin
        pos_mv = pos_q;
        unique case (bus.dir)
            DIR_U: if (pos_q.y > Y_MIN) begin
                if (!(ht_m1[TILE_LOG2] && col_hit)) pos_mv.y = pos_q.y - COORD_W'(1);
                else if (slide_l)                   pos_mv.x = pos_q.x - COORD_W'(1);
                else if (slide_r)                   pos_mv.x = pos_q.x + COORD_W'(1);
            end
            DIR_D: if (pos_q.y < Y_MAX) begin
                if (!(hb_p1[TILE_LOG2] && col_hit)) pos_mv.y = pos_q.y + COORD_W'(1);
                else if (slide_l)                   pos_mv.x = pos_q.x - COORD_W'(1);
                else if (slide_r)                   pos_mv.x = pos_q.x + COORD_W'(1);
            end
            DIR_L: if (pos_q.x > X_MIN) begin
                if (!(hl_m1[TILE_LOG2] && row_hit)) pos_mv.x = pos_q.x - COORD_W'(1);
                else if (slide_u)                   pos_mv.y = pos_q.y - COORD_W'(1);
                else if (slide_d)                   pos_mv.y = pos_q.y + COORD_W'(1);
            end
            DIR_R: if (pos_q.x < X_MAX) begin
                if (!(hr_p1[TILE_LOG2] && row_hit)) pos_mv.x = pos_q.x + COORD_W'(1);
                else if (slide_u)                   pos_mv.y = pos_q.y - COORD_W'(1);
                else if (slide_d)                   pos_mv.y = pos_q.y + COORD_W'(1);
            end
        endcase
    end

    // load beats freeze beats tick; freeze and load already gate the divider.
    logic [COORD_W-1:0] nx_rel, ny_rel;
    logic               aligned_nxt;

    always_comb begin
        pos_nxt   = pos_q;
        phase_nxt = phase_q;
        if (bus.load) begin
            pos_nxt.x = bus.ld_x;
            pos_nxt.y = bus.ld_y;
        end else if (mv_tick) begin
            pos_nxt = pos_mv;
        end
        if (bus.load || !bus.go) begin
            phase_nxt = 2'd0;
        end else if (fr_tick) begin
            phase_nxt = phase_q + 2'd1;
        end
    end

    assign nx_rel      = pos_nxt.x - X_MIN;
    assign ny_rel      = pos_nxt.y + COORD_W'(HB_OFF) - COORD_W'(AY0);
    assign aligned_nxt = (nx_rel[TILE_LOG2-1:0] == '0) && (ny_rel[TILE_LOG2-1:0] == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q.x   <= COORD_W'(START_X);
            pos_q.y   <= COORD_W'(START_Y);
            phase_q   <= 2'd0;
            frame_q   <= FRAME_STAND;
            step_q    <= 1'b0;
            mirror_q  <= 1'b0;
            aligned_q <= ALIGN_RST;
        end else begin
            pos_q     <= pos_nxt;
            phase_q   <= phase_nxt;
            frame_q   <= bus.dead ? FRAME_DEATH : phase_frame(phase_nxt);
            step_q    <= bus.load || (pos_nxt != pos_q);
            mirror_q  <= (bus.dir == DIR_L);
            aligned_q <= aligned_nxt;
        end
    end

    assign bus.x_s     = pos_q.x;
    assign bus.y_s     = pos_q.y;
    assign bus.frame   = frame_q;
    assign bus.step    = step_q;
    assign bus.mirror  = mirror_q;
    assign bus.aligned = aligned_q;

    // Pixel hit tests against the registered position.
    logic [CW1-1:0] x_end, y_end, hb_top;
    logic           in_x;

    assign x_end  = CW1'(pos_q.x) + CW1'(SPR_W);
    assign y_end  = CW1'(pos_q.y) + CW1'(SPR_H);
    assign hb_top = CW1'(pos_q.y) + CW1'(HB_OFF);
    assign in_x   = (bus.x >= pos_q.x) && (CW1'(bus.x) < x_end);

    assign bus.sprite_on = in_x && (bus.y >= pos_q.y) && (CW1'(bus.y) < y_end);
    assign bus.hb_on     = in_x && (CW1'(bus.y) >= hb_top) && (CW1'(bus.y) < y_end);

endmodule

// File: tb/tb_grid_sprite_ctrl.sv
// Directed self-checking bench for grid_sprite_ctrl with shortened periods.
module tb_grid_sprite_ctrl;
    import grid_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    grid_sprite_ctrl_if #(.SPD_W(2)) bus ();

    grid_sprite_ctrl #(
        .BASE_PERIOD  (8),
        .PERIOD_STEP  (2),
        .FRAME_PERIOD (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic wait_step(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.step !== 1'b1 && n < budget);
    endtask

    task automatic count_steps(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.step === 1'b1) cnt++;
        end
    endtask

    task automatic do_load(input logic [9:0] lx, input logic [9:0] ly);
        bus.load = 1'b1;
        bus.ld_x = lx;
        bus.ld_y = ly;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.x_s !== 10'd64) begin errors++; $display("FAIL rst_x: got %0d want 64", bus.x_s); end
        checks++; if (bus.y_s !== 10'd23) begin errors++; $display("FAIL rst_y: got %0d want 23", bus.y_s); end
        checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL rst_step: got %b want 0", bus.step); end
        checks++; if (bus.frame !== FRAME_STAND) begin errors++; $display("FAIL rst_frame: got %0d want 0", bus.frame); end
        checks++; if (bus.aligned !== 1'b1) begin errors++; $display("FAIL rst_aligned: got %b want 1", bus.aligned); end
        reset = 1'b1;
        @(negedge clk);
        bus.dir = DIR_R; bus.speed = 2'd3; bus.go = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (bus.x_s !== 10'd70) begin errors++; $display("FAIL move_x: got %0d want 70", bus.x_s); end
        checks++; if (bus.frame !== FRAME_WALKB) begin errors++; $display("FAIL move_frame: got %0d want 2", bus.frame); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.x_s !== 10'd64) begin errors++; $display("FAIL arst_x: got %0d want 64", bus.x_s); end
        checks++; if (bus.y_s !== 10'd23) begin errors++; $display("FAIL arst_y: got %0d want 23", bus.y_s); end
        checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL arst_step: got %b want 0", bus.step); end
        checks++; if (bus.frame !== FRAME_STAND) begin errors++; $display("FAIL arst_frame: got %0d want 0", bus.frame); end
        bus.go = 1'b0; bus.speed = 2'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_speed();
        int n;
        bus.dir = DIR_R; bus.speed = 2'd0; bus.go = 1'b1;
        wait_step(20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL spd0_gap1: got %0d clk want 8", n); end
        checks++; if (bus.x_s !== 10'd65) begin errors++; $display("FAIL spd0_x1: got %0d want 65", bus.x_s); end
        wait_step(20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL spd0_gap2: got %0d clk want 8", n); end
        repeat (5) @(negedge clk);
        bus.speed = 2'd3;
        wait_step(20, n);
        checks++; if (n !== 1) begin errors++; $display("FAIL spd_raise: got %0d clk want 1", n); end
        checks++; if (bus.x_s !== 10'd67) begin errors++; $display("FAIL spd_raise_x: got %0d want 67", bus.x_s); end
        for (int i = 0; i < 2; i++) begin
            wait_step(20, n);
            checks++; if (n !== 2) begin errors++; $display("FAIL spd3_gap%0d: got %0d clk want 2", i, n); end
        end
        checks++; if (bus.x_s !== 10'd69) begin errors++; $display("FAIL spd3_x: got %0d want 69", bus.x_s); end
        bus.go = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pillar();
        do_load(10'd64, 10'd23);
        bus.dir = DIR_D; bus.speed = 2'd3; bus.go = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (bus.y_s !== 10'd23) begin errors++; $display("FAIL pillar_block_y: got %0d want 23", bus.y_s); end
        bus.go = 1'b0;
        @(negedge clk);
        do_load(10'd62, 10'd23);
        bus.go = 1'b1;
        repeat (28) @(negedge clk);
        checks++; if (bus.x_s !== 10'd48) begin errors++; $display("FAIL slide_x: got %0d want 48", bus.x_s); end
        checks++; if (bus.y_s !== 10'd23) begin errors++; $display("FAIL slide_y: got %0d want 23", bus.y_s); end
        checks++; if (bus.aligned !== 1'b1) begin errors++; $display("FAIL slide_aligned: got %b want 1", bus.aligned); end
        repeat (12) @(negedge clk);
        checks++; if (bus.x_s !== 10'd48) begin errors++; $display("FAIL down_x: got %0d want 48", bus.x_s); end
        checks++; if (bus.y_s !== 10'd29) begin errors++; $display("FAIL down_y: got %0d want 29", bus.y_s); end
        checks++; if (bus.aligned !== 1'b0) begin errors++; $display("FAIL down_aligned: got %b want 0", bus.aligned); end
        bus.go = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bounds();
        int cnt;
        do_load(10'd48, 10'd23);
        bus.dir = DIR_L; bus.speed = 2'd3; bus.go = 1'b1;
        count_steps(100, cnt);
        checks++; if (cnt !== 0) begin errors++; $display("FAIL left_bound_steps: got %0d want 0", cnt); end
        checks++; if (bus.x_s !== 10'd48) begin errors++; $display("FAIL left_bound_x: got %0d want 48", bus.x_s); end
        bus.go = 1'b0;
        @(negedge clk);
        do_load(10'd559, 10'd23);
        bus.dir = DIR_R; bus.go = 1'b1;
        count_steps(20, cnt);
        checks++; if (cnt !== 1) begin errors++; $display("FAIL right_bound_steps: got %0d want 1", cnt); end
        checks++; if (bus.x_s !== 10'd560) begin errors++; $display("FAIL right_bound_x: got %0d want 560", bus.x_s); end
        bus.go = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_freeze();
        int n;
        int cnt;
        do_load(10'd64, 10'd23);
        bus.dir = DIR_R; bus.speed = 2'd0; bus.go = 1'b1;
        repeat (7) @(negedge clk);
        bus.freeze = 1'b1;
        do_load(10'd100, 10'd40);
        checks++; if (bus.x_s !== 10'd100) begin errors++; $display("FAIL ldfz_x: got %0d want 100", bus.x_s); end
        checks++; if (bus.y_s !== 10'd40) begin errors++; $display("FAIL ldfz_y: got %0d want 40", bus.y_s); end
        checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL ldfz_step: got %b want 1", bus.step); end
        count_steps(20, cnt);
        checks++; if (cnt !== 0) begin errors++; $display("FAIL freeze_steps: got %0d want 0", cnt); end
        checks++; if (bus.x_s !== 10'd100) begin errors++; $display("FAIL freeze_x: got %0d want 100", bus.x_s); end
        bus.freeze = 1'b0;
        wait_step(20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL unfreeze_gap: got %0d clk want 8", n); end
        checks++; if (bus.x_s !== 10'd101) begin errors++; $display("FAIL unfreeze_x: got %0d want 101", bus.x_s); end
        repeat (7) @(negedge clk);
        do_load(10'd100, 10'd40);
        checks++; if (bus.x_s !== 10'd100) begin errors++; $display("FAIL ld_tick_x: got %0d want 100", bus.x_s); end
        checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL ld_tick_step: got %b want 1", bus.step); end
        wait_step(20, n);
        checks++; if (n !== 8) begin errors++; $display("FAIL ld_timer_clear: got %0d clk want 8", n); end
        bus.go = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_animation();
        logic [1:0] exp_frame [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                                       2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        do_load(10'd64, 10'd23);
        bus.dir = DIR_U; bus.go = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (bus.frame !== exp_frame[k]) begin
                errors++; $display("FAIL anim_clk%0d: got %0d want %0d", k + 1, bus.frame, exp_frame[k]);
            end
        end
        repeat (5) @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        checks++; if (bus.frame !== FRAME_STAND) begin errors++; $display("FAIL idle_frame: got %0d want 0", bus.frame); end
        bus.dead = 1'b1;
        @(negedge clk);
        checks++; if (bus.frame !== FRAME_DEATH) begin errors++; $display("FAIL dead_frame: got %0d want 3", bus.frame); end
        bus.dead = 1'b0;
        checks++; if (bus.mirror !== 1'b0) begin errors++; $display("FAIL mirror_up: got %b want 0", bus.mirror); end
        bus.dir = DIR_L;
        @(negedge clk);
        checks++; if (bus.mirror !== 1'b1) begin errors++; $display("FAIL mirror_left: got %b want 1", bus.mirror); end
        bus.dir = DIR_U;
        @(negedge clk);
    endtask

    task automatic test_hitbox();
        logic [9:0] vx [7] = '{10'd64, 10'd79, 10'd80, 10'd63, 10'd70, 10'd70, 10'd70};
        logic [9:0] vy [7] = '{10'd23, 10'd47, 10'd40, 10'd40, 10'd32, 10'd31, 10'd48};
        logic       vs [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       vh [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            bus.x = vx[i]; bus.y = vy[i];
            #1;
            checks++;
            if (bus.sprite_on !== vs[i]) begin
                errors++; $display("FAIL sprite_on_%0d_%0d: got %b want %b", vx[i], vy[i], bus.sprite_on, vs[i]);
            end
            checks++;
            if (bus.hb_on !== vh[i]) begin
                errors++; $display("FAIL hb_on_%0d_%0d: got %b want %b", vx[i], vy[i], bus.hb_on, vh[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.x = '0; bus.y = '0; bus.go = 1'b0; bus.dir = DIR_U; bus.speed = '0;
        bus.freeze = 1'b0; bus.dead = 1'b0; bus.load = 1'b0; bus.ld_x = '0; bus.ld_y = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_speed();
        test_pillar();
        test_bounds();
        test_load_freeze();
        test_animation();
        test_hitbox();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
